// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Imported by the byte packer and the loader top level.
package inst_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        DATA,
        RESP
    } state_t;

    localparam logic [7:0] ACK_DEFAULT = 8'hAA;
    localparam logic [7:0] NAK_DEFAULT = 8'h55;

    // Bytes per length field and per instruction word
    localparam int FRAME_LEN_BYTES = 4;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words.
// word/word_valid are combinational on the byte completing a word.
module byte_packer
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST = 2'(FRAME_LEN_BYTES - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d;

    // New byte enters at the top so the first byte ends up in bits 7:0
    always_comb begin
        word       = {in_byte, sr_q[31:8]};
        word_valid = in_valid && (cnt_q == LAST);
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        if (clr) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (in_valid) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = word;
        end
    end

    // Byte counter and shift register state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// UART program loader: length-prefixed frame to instruction RAM.
// Replies ACK on a good load, NAK on bad length or timeout.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter logic [7:0]  ACK_BYTE    = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE    = NAK_DEFAULT,
    parameter logic [31:0] TIMEOUT_CYC = 32'd0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       di,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [31:0]       n_q, n_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [31:0]       to_cnt_q, to_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       di_q, di_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        pk_valid;
    logic        pk_clr;
    logic        pk_word_valid;
    logic [31:0] pk_word;
    logic        timeout_hit;

    assign pk_valid = rx_valid && (state_q == LEN || state_q == DATA);
    assign pk_clr   = (state_d != state_q);

    assign timeout_hit = (TIMEOUT_CYC != 32'd0) && !rx_valid &&
                         (to_cnt_q == TIMEOUT_CYC - 32'd1);

    byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (pk_clr),
        .in_valid   (pk_valid),
        .in_byte    (rx_data),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    // Frame FSM next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        to_cnt_d   = to_cnt_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        di_d       = di_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LEN;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    n_d        = '0;
                    word_cnt_d = '0;
                    to_cnt_d   = '0;
                end
            end
            LEN: begin
                to_cnt_d = rx_valid ? '0 : to_cnt_q + 32'd1;
                if (timeout_hit) begin
                    state_d    = RESP;
                    tx_valid_d = 1'b1;
                    tx_data_d  = NAK_BYTE;
                    err_d      = 1'b1;
                end else if (pk_word_valid) begin
                    n_d = pk_word;
                    if (pk_word == 32'd0) begin
                        state_d    = RESP;
                        tx_valid_d = 1'b1;
                        tx_data_d  = ACK_BYTE;
                    end else if (pk_word > MAX_WORDS) begin
                        state_d    = RESP;
                        tx_valid_d = 1'b1;
                        tx_data_d  = NAK_BYTE;
                        err_d      = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                to_cnt_d = rx_valid ? '0 : to_cnt_q + 32'd1;
                if (32'(word_cnt_q) == n_q) begin
                    state_d    = RESP;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_BYTE;
                end else if (timeout_hit) begin
                    state_d    = RESP;
                    tx_valid_d = 1'b1;
                    tx_data_d  = NAK_BYTE;
                    err_d      = 1'b1;
                end else if (pk_word_valid) begin
                    we_d       = 1'b1;
                    waddr_d    = word_cnt_q[ADDR_W-1:0];
                    di_d       = pk_word;
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (tx_ready) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = !err_q;
                end
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            n_q        <= '0;
            word_cnt_q <= '0;
            to_cnt_q   <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            di_q       <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            to_cnt_q   <= to_cnt_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            di_q       <= di_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign di       = di_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
